// File: rtl/mant_sqrt_datapath.sv
// Radix-2 restoring square-root datapath: retires one root bit per enabled cycle
// and reports the integer root plus a sticky (nonzero remainder) bit.
module mant_sqrt_datapath #(
    parameter int unsigned ROOT_W = 55
) (
    input  logic                  in_Clk,
    input  logic                  in_Rst,
    input  logic                  in_load,
    input  logic                  in_shift_en,
    input  logic [2*ROOT_W-1:0]   in_radicand,
    output logic [ROOT_W-1:0]     out_root,
    output logic                  out_sticky,
    output logic                  out_busy,
    output logic                  out_done
);

    localparam int unsigned CNT_W = $clog2(ROOT_W + 1);

    logic [2*ROOT_W-1:0] r_rad;
    logic [ROOT_W+1:0]   r_rem;
    logic [ROOT_W-1:0]   r_root;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_done;

    logic [ROOT_W+1:0]   w_trial;
    logic [ROOT_W+1:0]   w_test;
    logic [ROOT_W+1:0]   w_diff;
    logic                w_ge;
    logic                w_active;

    // Bring down the next radicand pair and compare against 4*root+1.
    assign w_trial  = {r_rem[ROOT_W-1:0], r_rad[2*ROOT_W-1 -: 2]};
    assign w_test   = {r_root, 2'b01};
    assign w_diff   = w_trial - w_test;
    assign w_ge     = (w_trial >= w_test);
    assign w_active = in_shift_en && (r_cnt < CNT_W'(ROOT_W));

    always_ff @(posedge in_Clk) begin
        if (in_Rst) begin
            r_rad  <= '0;
            r_rem  <= '0;
            r_root <= '0;
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else if (in_load) begin
            r_rad  <= in_radicand;
            r_rem  <= '0;
            r_root <= '0;
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else if (w_active) begin
            r_rem  <= w_ge ? w_diff : w_trial;
            r_root <= {r_root[ROOT_W-2:0], w_ge};
            r_rad  <= {r_rad[2*ROOT_W-3:0], 2'b00};
            r_cnt  <= r_cnt + 1'b1;
            if (r_cnt == CNT_W'(ROOT_W - 1)) begin
                r_done <= 1'b1;
            end
        end
    end

    assign out_root   = r_root;
    assign out_sticky = r_done & (r_rem != '0);
    assign out_done   = r_done;
    assign out_busy   = (r_cnt != '0) & ~r_done;

endmodule
